// File: rtl/circle_buf_drain.sv
// Read-side sequencer for the double-banked circular capture buffer.
// Strobes a filled bank, skids the read latency, streams one frame per bank.
module circle_buf_drain #(
  parameter int aw = 13,
  parameter int dw = 16,
  parameter int fd = 4
) (
  input  logic          rclk,
  input  logic          reset,
  input  logic          enable,
  input  logic          replay,
  input  logic          bank_avail,
  input  logic [dw-1:0] buf_data,
  input  logic          buf_gate,
  output logic          stb_r,
  output logic          rewind,
  output logic [dw-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic          busy,
  output logic [15:0]   frame_cnt,
  output logic          err_ovf
);

  localparam int pw = $clog2(fd);
  localparam int cw = pw + 1;
  localparam logic [aw:0] last_idx = {1'b0, {aw{1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    REWIND
  } state_t;

  state_t state, state_n;

  logic [aw:0]     issue_cnt;
  logic [aw:0]     deliv_cnt;
  logic [cw-1:0]   fifo_cnt;
  logic [cw-1:0]   inflight;
  logic [pw-1:0]   wr_ptr;
  logic [pw-1:0]   rd_ptr;
  logic [dw-1:0]   mem [fd];

  logic flush;
  logic discard;
  logic fifo_full;
  logic room;
  logic push;
  logic push_ok;
  logic pop;
  logic frame_done;

  // Strobes in flight count against FIFO space so a stalled
  // consumer can never cause a returning word to be dropped.
  assign room = ({1'b0, fifo_cnt} + {1'b0, inflight})
                < (cw+1)'(fd);

  assign flush      = (state == READ) && replay;
  assign discard    = flush || (state == REWIND);
  assign fifo_full  = fifo_cnt == cw'(fd);
  assign m_valid    = fifo_cnt != '0;
  assign m_data     = mem[rd_ptr];
  assign pop        = m_valid && m_ready;
  assign push       = buf_gate && !discard;
  assign push_ok    = push && (!fifo_full || pop);
  assign m_last     = m_valid && (deliv_cnt == last_idx);
  assign frame_done = pop && m_last && (state == DRAIN);
  assign busy       = state != IDLE;

  always_comb begin
    state_n = state;
    stb_r   = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && bank_avail)
          state_n = READ;
      end
      READ: begin
        if (replay) begin
          state_n = REWIND;
        end else begin
          stb_r = bank_avail && room;
          if (stb_r && (issue_cnt == last_idx))
            state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (frame_done)
          state_n = IDLE;
      end
      REWIND: begin
        if (inflight == '0)
          state_n = READ;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      state     <= IDLE;
      rewind    <= 1'b0;
      issue_cnt <= '0;
      deliv_cnt <= '0;
      fifo_cnt  <= '0;
      inflight  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      frame_cnt <= '0;
      err_ovf   <= 1'b0;
    end else begin
      state    <= state_n;
      rewind   <= flush;
      inflight <= inflight + cw'(stb_r) - cw'(buf_gate);
      if (push && fifo_full && !pop)
        err_ovf <= 1'b1;
      if (frame_done)
        frame_cnt <= frame_cnt + 16'd1;
      if (flush) begin
        fifo_cnt  <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        issue_cnt <= '0;
        deliv_cnt <= '0;
      end else begin
        if (push_ok)
          wr_ptr <= wr_ptr + pw'(1);
        if (pop)
          rd_ptr <= rd_ptr + pw'(1);
        fifo_cnt <= fifo_cnt + cw'(push_ok) - cw'(pop);
        if (frame_done) begin
          issue_cnt <= '0;
          deliv_cnt <= '0;
        end else begin
          issue_cnt <= issue_cnt + (aw+1)'(stb_r);
          if (pop)
            deliv_cnt <= deliv_cnt + (aw+1)'(1);
        end
      end
    end
  end

  always_ff @(posedge rclk) begin
    if (push_ok)
      mem[wr_ptr] <= buf_data;
  end

endmodule

// File: tb/tb_circle_buf_drain.sv
// Bench for circle_buf_drain: buffer model with 1-cycle read latency,
// scoreboard of expected frame words checked on every stream accept.
module tb_circle_buf_drain;

  localparam int AW = 3;
  localparam int DW = 16;
  localparam int FD = 4;

  logic          rclk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          replay = 1'b0;
  logic          bank_avail;
  logic [DW-1:0] buf_data = '0;
  logic          buf_gate = 1'b0;
  logic          m_ready = 1'b0;
  logic          stb_r;
  logic          rewind;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          busy;
  logic [15:0]   frame_cnt;
  logic          err_ovf;

  circle_buf_drain #(.aw(AW), .dw(DW), .fd(FD)) dut (
    .rclk(rclk),
    .reset(reset),
    .enable(enable),
    .replay(replay),
    .bank_avail(bank_avail),
    .buf_data(buf_data),
    .buf_gate(buf_gate),
    .stb_r(stb_r),
    .rewind(rewind),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_last(m_last),
    .busy(busy),
    .frame_cnt(frame_cnt),
    .err_ovf(err_ovf)
  );

  always #5 rclk = ~rclk;

  int total = 0;
  int bad = 0;

  // buffer model: word = frame*16 + address
  int fills = 0;
  int consumed = 0;
  logic [AW-1:0] raddr = '0;
  assign bank_avail = fills != consumed;

  always @(posedge rclk) begin
    if (reset) begin
      buf_gate <= 1'b0;
      raddr    <= '0;
      consumed <= fills;
    end else begin
      buf_gate <= stb_r;
      if (stb_r) begin
        buf_data <= 16'(consumed * 16 + int'(raddr));
        raddr    <= raddr + 3'd1;
        if (raddr == 3'd7)
          consumed <= consumed + 1;
      end
      if (rewind)
        raddr <= '0;
    end
  end

  logic [DW:0] exp_q[$];
  int stb_cnt = 0;
  int rw_cnt = 0;
  int acc_cnt = 0;
  int last_cnt = 0;
  int acc_in_frame = 0;

  always @(negedge rclk) begin
    if (!reset) begin
      if (stb_r) stb_cnt++;
      if (rewind) rw_cnt++;
      if (m_valid && m_ready) begin
        logic [DW:0] e;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL stream_extra: got data=%h, required no word",
                   m_data);
        end else begin
          e = exp_q.pop_front();
          if ({m_last, m_data} !== e) begin
            bad++;
            $display("FAIL stream_word: got last=%0b data=%h, required last=%0b data=%h",
                     m_last, m_data, e[DW], e[DW-1:0]);
          end
        end
        acc_cnt++;
        if (m_last) begin
          last_cnt++;
          acc_in_frame = 0;
        end else begin
          acc_in_frame++;
        end
      end
    end
  end

  task automatic fill();
    for (int i = 0; i < 8; i++)
      exp_q.push_back({(i == 7), 16'(fills * 16 + i)});
    fills++;
  endtask

  task automatic wait_frames(input logic [15:0] tgt, input int budget);
    int n = 0;
    while (frame_cnt !== tgt && n < budget) begin
      @(posedge rclk); #1;
      n++;
    end
    total++;
    if (frame_cnt !== tgt) begin
      bad++;
      $display("FAIL frame_wait: frame_cnt=%0d, required %0d", frame_cnt, tgt);
    end
  endtask

  task automatic wait_stb(input int tgt, input int budget);
    int n = 0;
    while (stb_cnt < tgt && n < budget) begin
      @(posedge rclk); #1;
      n++;
    end
    total++;
    if (stb_cnt < tgt) begin
      bad++;
      $display("FAIL stb_wait: strobes=%0d, required %0d", stb_cnt, tgt);
    end
  endtask

  task automatic wait_acc(input int tgt, input int budget);
    int n = 0;
    while (acc_cnt < tgt && n < budget) begin
      @(posedge rclk); #1;
      n++;
    end
    total++;
    if (acc_cnt < tgt) begin
      bad++;
      $display("FAIL acc_wait: accepts=%0d, required %0d", acc_cnt, tgt);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge rclk);
    #1;
    total++;
    if ({stb_r, rewind, m_valid, m_last, busy, err_ovf} !== 6'b0 ||
        frame_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_state: outs=%b fc=%0d, required 000000 fc=0",
               {stb_r, rewind, m_valid, m_last, busy, err_ovf}, frame_cnt);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_frame();
    int nstb = 0, f_stb = -1, l_stb = -1, f_v = -1;
    int l_acc = -1, nlast = 0;
    logic busy_after = 1'b1;
    @(posedge rclk); #1;
    m_ready = 1'b1;
    fill();
    enable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge rclk);
      if (stb_r) begin
        if (nstb == 0) f_stb = i;
        l_stb = i;
        nstb++;
      end
      if (m_valid && f_v < 0) f_v = i;
      if (m_valid && m_ready && m_last) begin
        l_acc = i;
        nlast++;
      end
      if (nlast > 0 && i == l_acc + 1) busy_after = busy;
    end
    total++;
    if (nstb != 8 || l_stb - f_stb != 7) begin
      bad++;
      $display("FAIL strobe_run: n=%0d span=%0d, required n=8 span=7",
               nstb, l_stb - f_stb);
    end
    total++;
    if (f_v - f_stb != 2) begin
      bad++;
      $display("FAIL first_latency: %0d, required 2", f_v - f_stb);
    end
    total++;
    if (l_acc - f_stb != 9 || nlast != 1) begin
      bad++;
      $display("FAIL frame_time: %0d lasts=%0d, required 9 lasts=1",
               l_acc - f_stb, nlast);
    end
    total++;
    if (busy_after !== 1'b0 || frame_cnt !== 16'd1) begin
      bad++;
      $display("FAIL frame_end: busy=%b fc=%0d, required busy=0 fc=1",
               busy_after, frame_cnt);
    end
  endtask

  task automatic test_backpressure();
    int sb = stb_cnt;
    int ab = acc_cnt;
    logic [15:0] fb = frame_cnt;
    @(posedge rclk); #1;
    fill();
    wait_acc(ab + 2, 40);
    m_ready = 1'b0;
    repeat (20) @(posedge rclk);
    #1;
    total++;
    if (stb_cnt - sb != 6) begin
      bad++;
      $display("FAIL stall_strobes: %0d, required 6", stb_cnt - sb);
    end
    total++;
    if (err_ovf !== 1'b0 || m_valid !== 1'b1) begin
      bad++;
      $display("FAIL stall_state: ovf=%b valid=%b, required ovf=0 valid=1",
               err_ovf, m_valid);
    end
    m_ready = 1'b1;
    wait_frames(fb + 16'd1, 40);
    total++;
    if (acc_cnt - ab != 8) begin
      bad++;
      $display("FAIL stall_words: %0d, required 8", acc_cnt - ab);
    end
  endtask

  task automatic test_replay();
    int sb = stb_cnt;
    int rb = rw_cnt;
    int ab = acc_cnt;
    int k;
    logic [15:0] fb = frame_cnt;
    @(posedge rclk); #1;
    fill();
    wait_stb(sb + 5, 40);
    m_ready = 1'b0;
    replay = 1'b1;
    k = acc_in_frame;
    for (int i = k - 1; i >= 0; i--)
      exp_q.push_front({1'b0, 16'(consumed * 16 + i)});
    @(posedge rclk); #1;
    replay = 1'b0;
    repeat (4) @(posedge rclk);
    #1;
    total++;
    if (rw_cnt - rb != 1) begin
      bad++;
      $display("FAIL rewind_pulse: cycles=%0d, required 1", rw_cnt - rb);
    end
    m_ready = 1'b1;
    wait_frames(fb + 16'd1, 60);
    repeat (3) @(posedge rclk);
    #1;
    total++;
    if (frame_cnt !== fb + 16'd1 || acc_cnt - ab != k + 8) begin
      bad++;
      $display("FAIL replay_frame: fc=%0d words=%0d, required fc=%0d words=%0d",
               frame_cnt, acc_cnt - ab, fb + 16'd1, k + 8);
    end
  endtask

  task automatic test_replay_ignored();
    int sb = stb_cnt;
    int rb = rw_cnt;
    logic [15:0] fb = frame_cnt;
    @(posedge rclk); #1;
    fill();
    wait_stb(sb + 8, 40);
    replay = 1'b1;
    @(posedge rclk); #1;
    replay = 1'b0;
    wait_frames(fb + 16'd1, 40);
    repeat (2) @(posedge rclk);
    #1;
    replay = 1'b1;
    @(posedge rclk); #1;
    replay = 1'b0;
    repeat (3) @(posedge rclk);
    #1;
    total++;
    if (rw_cnt != rb || busy !== 1'b0 || m_valid !== 1'b0 ||
        frame_cnt !== fb + 16'd1) begin
      bad++;
      $display("FAIL replay_ignored: rw=%0d busy=%b valid=%b fc=%0d, required rw=0 busy=0 valid=0 fc=%0d",
               rw_cnt - rb, busy, m_valid, frame_cnt, fb + 16'd1);
    end
  endtask

  task automatic test_mid_reset();
    int sb = stb_cnt;
    @(posedge rclk); #1;
    m_ready = 1'b0;
    fill();
    wait_stb(sb + 3, 40);
    enable = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    @(posedge rclk); #1;
    total++;
    if ({stb_r, rewind, m_valid, m_last, busy, err_ovf} !== 6'b0 ||
        frame_cnt !== 16'd0) begin
      bad++;
      $display("FAIL mid_reset: outs=%b fc=%0d, required 000000 fc=0",
               {stb_r, rewind, m_valid, m_last, busy, err_ovf}, frame_cnt);
    end
    reset = 1'b0;
    repeat (3) @(posedge rclk);
    #1;
    total++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || stb_r !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: busy=%b valid=%b stb=%b, required 0 0 0",
               busy, m_valid, stb_r);
    end
  endtask

  task automatic test_back_to_back();
    int ab = acc_cnt;
    int lb = last_cnt;
    @(posedge rclk); #1;
    m_ready = 1'b1;
    enable = 1'b1;
    fill();
    fill();
    wait_frames(16'd2, 80);
    repeat (3) @(posedge rclk);
    #1;
    total++;
    if (acc_cnt - ab != 16 || last_cnt - lb != 2 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL back_to_back: words=%0d lasts=%0d left=%0d, required 16 2 0",
               acc_cnt - ab, last_cnt - lb, exp_q.size());
    end
    total++;
    if (err_ovf !== 1'b0 || frame_cnt !== 16'd2) begin
      bad++;
      $display("FAIL final_state: ovf=%b fc=%0d, required ovf=0 fc=2",
               err_ovf, frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_replay();
    test_replay_ignored();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
